mac_batch_arbiter: RTL and testbench

//  Shares one mac unit (and its 64-entry result memory) between NUM_REQ requesters.

---
 rtl/mac_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mac_batch_arbiter.sv | 151 +++++++++++++++
 tb/tb_mac_batch_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC batch arbiter and its round-robin picker.
package mac_pkg;
  localparam int MAC_MEM_DEPTH = 64;

  typedef logic [3:0][15:0] vec4x16_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RD_REQ,
    DRAIN
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting line at or after ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic found;

  // Outer loop walks the circular search order; inner loop keeps every bit select constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (en && !found && req[j] && (j == (int'(ptr) + i) % N)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_batch_arbiter.sv
// Shares one mac among NUM_REQ requesters, one whole batch (fill, block read, drain) at a time.
module mac_batch_arbiter
  import mac_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int BATCH_LEN = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      gnt,
  input  logic [NUM_REQ-1:0]      beat_valid,
  output logic                    beat_ready,
  input  logic [NUM_REQ*64-1:0]   req_vectA,
  input  logic [NUM_REQ*64-1:0]   req_vectB,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_last,
  output logic                    EN_mac,
  input  logic                    RDY_mac,
  output logic [15:0]             mac_vectA_0,
  output logic [15:0]             mac_vectA_1,
  output logic [15:0]             mac_vectA_2,
  output logic [15:0]             mac_vectA_3,
  output logic [15:0]             mac_vectB_0,
  output logic [15:0]             mac_vectB_1,
  output logic [15:0]             mac_vectB_2,
  output logic [15:0]             mac_vectB_3,
  output logic                    EN_blockRead,
  input  logic                    RDY_blockRead,
  input  logic                    VALID_memVal,
  input  logic [31:0]             memVal_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BATCH_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BATCH_LEN - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [PW-1:0]       gnt_idx;
  logic                fill_st, g_valid, fill_fire, rsp_fire, at_last;
  vec4x16_t            vec_a, vec_b, out_a, out_b;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (rr_ptr_q),
    .en    (state_q == IDLE),
    .grant (arb_grant)
  );

  // gnt_q is one-hot, so OR-ing the selected slices is a plain mux.
  always_comb begin
    vec_a   = '0;
    vec_b   = '0;
    gnt_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_q[j]) begin
        vec_a   = req_vectA[j*64 +: 64];
        vec_b   = req_vectB[j*64 +: 64];
        gnt_idx = PW'(j);
      end
    end
  end

  assign fill_st   = (state_q == FILL);
  assign g_valid   = |(beat_valid & gnt_q);
  assign fill_fire = fill_st && g_valid && RDY_mac;
  // The first result beat is consumed in RD_REQ itself, so both states drain.
  assign rsp_fire  = ((state_q == RD_REQ) || (state_q == DRAIN)) && VALID_memVal;
  assign at_last   = (beat_cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          gnt_d      = arb_grant;
          beat_cnt_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (fill_fire) begin
          if (at_last) begin
            beat_cnt_d = '0;
            state_d    = RD_REQ;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      RD_REQ, DRAIN: begin
        if (rsp_fire) begin
          if (at_last) begin
            gnt_d      = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Vectors are forced to zero outside FILL so the mac never sees stale lanes.
  assign out_a = fill_st ? vec_a : '0;
  assign out_b = fill_st ? vec_b : '0;

  assign gnt          = gnt_q;
  assign beat_ready   = fill_st && RDY_mac;
  assign EN_mac       = fill_fire;
  assign mac_vectA_0  = out_a[0];
  assign mac_vectA_1  = out_a[1];
  assign mac_vectA_2  = out_a[2];
  assign mac_vectA_3  = out_a[3];
  assign mac_vectB_0  = out_b[0];
  assign mac_vectB_1  = out_b[1];
  assign mac_vectB_2  = out_b[2];
  assign mac_vectB_3  = out_b[3];
  assign EN_blockRead = (state_q == RD_REQ) && RDY_blockRead;
  assign rsp_valid    = rsp_fire ? gnt_q : '0;
  assign rsp_data     = rsp_fire ? memVal_data : '0;
  assign rsp_last     = rsp_fire && at_last;

endmodule

// File: tb/tb_mac_batch_arbiter.sv
// Bench for mac_batch_arbiter: behavioural mac/result-memory model plus a per-requester scoreboard.
module tb_mac_batch_arbiter;
  import mac_pkg::*;

  localparam int NR = 2;
  localparam int BL = 64;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NR-1:0]     req;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     beat_valid;
  logic              beat_ready;
  logic [NR*64-1:0]  req_vectA;
  logic [NR*64-1:0]  req_vectB;
  logic [NR-1:0]     rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic              EN_mac;
  logic              RDY_mac;
  logic [15:0]       mac_vectA_0, mac_vectA_1, mac_vectA_2, mac_vectA_3;
  logic [15:0]       mac_vectB_0, mac_vectB_1, mac_vectB_2, mac_vectB_3;
  logic              EN_blockRead;
  logic              RDY_blockRead;
  logic              VALID_memVal;
  logic [31:0]       memVal_data;

  always #5 CLK = ~CLK;

  mac_batch_arbiter #(.NUM_REQ(NR), .BATCH_LEN(BL)) dut (
    .CLK(CLK), .RST(RST), .req(req), .gnt(gnt),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .req_vectA(req_vectA), .req_vectB(req_vectB),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .EN_mac(EN_mac), .RDY_mac(RDY_mac),
    .mac_vectA_0(mac_vectA_0), .mac_vectA_1(mac_vectA_1),
    .mac_vectA_2(mac_vectA_2), .mac_vectA_3(mac_vectA_3),
    .mac_vectB_0(mac_vectB_0), .mac_vectB_1(mac_vectB_1),
    .mac_vectB_2(mac_vectB_2), .mac_vectB_3(mac_vectB_3),
    .EN_blockRead(EN_blockRead), .RDY_blockRead(RDY_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data)
  );

  vec4x16_t    pa [NR][BL];
  vec4x16_t    pb [NR][BL];
  int          idx [NR];
  bit          tog [NR];
  bit          stall_mac, gap_mem, chk_follow;
  logic [31:0] mem [MAC_MEM_DEPTH];
  int          wr_ptr, rd_ptr, cyc, en_cnt, rsp_beat;
  bit          rd_busy;
  bit          f_fire [NR];
  bit          f_mac, f_blk, f_memv;
  logic [31:0] f_res;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          n_tests, n_fail;

  function automatic logic [31:0] dot(input vec4x16_t a, input vec4x16_t b);
    logic [31:0] s = '0;
    for (int l = 0; l < 4; l++) s = s + 32'(a[l]) * 32'(b[l]);
    return s;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got a result beat, expected none", nm);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_ctrl"}, {beat_ready, rsp_last, EN_mac, EN_blockRead, rsp_valid}, 0);
    check({tag, "_vect"}, {mac_vectA_0, mac_vectA_1, mac_vectA_2, mac_vectA_3,
                           mac_vectB_0, mac_vectB_1, mac_vectB_2, mac_vectB_3}, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  // Pair 0 of a corner batch is all-ones (sum wraps to FFF80004), the last pair has A=0.
  task automatic load_batch(input int r, input bit corner);
    logic [31:0] e;
    for (int i = 0; i < BL; i++) begin
      for (int l = 0; l < 4; l++) begin
        pa[r][i][l] = (corner && i == 0) ? 16'hFFFF : 16'($urandom);
        pb[r][i][l] = (corner && i == 0) ? 16'hFFFF : 16'($urandom);
      end
      if (corner && i == BL - 1) pa[r][i] = '0;
      if (corner && i == 0)           e = 32'hFFF8_0004;
      else if (corner && i == BL - 1) e = 32'h0;
      else                            e = dot(pa[r][i], pb[r][i]);
      if (r == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic wait_gnt(input logic [NR-1:0] v, input int budget, input string nm);
    int k = 0;
    while (gnt !== v && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check(nm, gnt, v);
  endtask

  // Requester drivers and mac model: update just after each rising edge.
  initial forever begin
    @(posedge CLK);
    #1;
    cyc++;
    if (RST) begin
      rd_busy = 1'b0;
      rd_ptr  = 0;
      wr_ptr  = 0;
      for (int r = 0; r < NR; r++) idx[r] = 0;
    end else begin
      for (int r = 0; r < NR; r++) if (f_fire[r]) idx[r]++;
      if (f_mac) begin
        mem[wr_ptr % MAC_MEM_DEPTH] = f_res;
        wr_ptr++;
      end
      if (rd_busy && f_memv) begin
        rd_ptr++;
        if (rd_ptr == BL) begin
          rd_busy = 1'b0;
          wr_ptr  = 0;
        end
      end else if (!rd_busy && f_blk) begin
        rd_busy = 1'b1;
        rd_ptr  = 0;
      end
      for (int r = 0; r < NR; r++) if (!gnt[r]) idx[r] = 0;
    end
    for (int r = 0; r < NR; r++) f_fire[r] = 1'b0;
    f_mac  = 1'b0;
    f_blk  = 1'b0;
    f_memv = 1'b0;
    for (int r = 0; r < NR; r++) begin
      beat_valid[r]         = (idx[r] < BL) && (!tog[r] || cyc[0]);
      req_vectA[r*64 +: 64] = pa[r][(idx[r] < BL) ? idx[r] : 0];
      req_vectB[r*64 +: 64] = pb[r][(idx[r] < BL) ? idx[r] : 0];
    end
    RDY_mac       = !(stall_mac && (cyc % 5 == 2));
    RDY_blockRead = !rd_busy;
    VALID_memVal  = rd_busy && !(gap_mem && (cyc % 3 == 1));
    memVal_data   = VALID_memVal ? mem[rd_ptr] : 32'hDEAD_BEEF;
  end

  // Monitor: records this cycle's handshakes and scores result beats mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      rsp_beat = 0;
    end else begin
      for (int r = 0; r < NR; r++) f_fire[r] = beat_valid[r] && beat_ready && gnt[r];
      f_mac  = EN_mac;
      f_res  = dot({mac_vectA_3, mac_vectA_2, mac_vectA_1, mac_vectA_0},
                   {mac_vectB_3, mac_vectB_2, mac_vectB_1, mac_vectB_0});
      f_blk  = EN_blockRead && RDY_blockRead;
      f_memv = VALID_memVal;
      if (EN_mac) en_cnt++;
      if (chk_follow && gnt[0] && beat_ready) check("en_mac_follows_valid", EN_mac, beat_valid[0]);
      if (rsp_valid != '0) begin
        check("rsp_valid_to_granted", rsp_valid, gnt);
        if (rsp_valid[0]) begin
          if (exp_q0.size() == 0) fail_now("rsp0_unexpected");
          else check("rsp0_data", rsp_data, exp_q0.pop_front());
        end
        if (rsp_valid[1]) begin
          if (exp_q1.size() == 0) fail_now("rsp1_unexpected");
          else check("rsp1_data", rsp_data, exp_q1.pop_front());
        end
        check("rsp_last", rsp_last, (rsp_beat == BL - 1));
        rsp_beat++;
      end else if (rsp_last) begin
        check("rsp_last_without_valid", rsp_last, 1'b0);
      end
      if (gnt == '0) rsp_beat = 0;
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, k;
    RST = 1'b1;
    req = '0;
    repeat (3) @(negedge CLK);
    check_zero("reset");

    // Both requesters held at reset release: 0 first, then 1.
    load_batch(0, 1'b0);
    load_batch(1, 1'b0);
    req = 2'b11;
    @(negedge CLK);
    RST = 1'b0;
    wait_gnt(2'b01, 4, "t2_first_gnt");
    req[0] = 1'b0;
    wait_gnt(2'b00, 1000, "t2_batch0_done");
    check("t2_q0_empty", exp_q0.size(), 0);
    check("t2_no_rsp1_in_batch0", exp_q1.size(), BL);
    wait_gnt(2'b10, 4, "t2_second_gnt");
    req[1] = 1'b0;
    wait_gnt(2'b00, 1000, "t2_batch1_done");
    check("t2_q1_empty", exp_q1.size(), 0);

    // Single requester 0 with corner operands.
    load_batch(0, 1'b1);
    req = 2'b01;
    wait_gnt(2'b01, 4, "t1_gnt");
    req = 2'b00;
    wait_gnt(2'b00, 1000, "t1_done");
    check("t1_q0_empty", exp_q0.size(), 0);

    // Toggling beat_valid plus mac back-pressure.
    tog[0]     = 1'b1;
    stall_mac  = 1'b1;
    chk_follow = 1'b1;
    start      = en_cnt;
    load_batch(0, 1'b0);
    req = 2'b01;
    wait_gnt(2'b01, 4, "t3_gnt");
    req = 2'b00;
    wait_gnt(2'b00, 1000, "t3_done");
    check("t3_transfer_count", en_cnt - start, BL);
    check("t3_q0_empty", exp_q0.size(), 0);
    tog[0]     = 1'b0;
    stall_mac  = 1'b0;
    chk_follow = 1'b0;

    // Reset mid-fill, then a clean batch.
    load_batch(0, 1'b0);
    req = 2'b01;
    wait_gnt(2'b01, 4, "t4_gnt");
    req = 2'b00;
    k = 0;
    while (idx[0] < 30 && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    check("t4_reached_beat30", idx[0], 30);
    #2 RST = 1'b1;
    #1 check_zero("t4_async_reset");
    repeat (2) @(negedge CLK);
    exp_q0.delete();
    RST = 1'b0;
    @(negedge CLK);
    check("t4_gnt_after_reset", gnt, 0);
    load_batch(0, 1'b0);
    req = 2'b01;
    wait_gnt(2'b01, 4, "t4_regnt");
    req = 2'b00;
    wait_gnt(2'b00, 1000, "t4_done");
    check("t4_q0_empty", exp_q0.size(), 0);

    // Requester 1 drops req mid-drain with memory gaps.
    gap_mem = 1'b1;
    load_batch(1, 1'b0);
    req = 2'b10;
    wait_gnt(2'b10, 4, "t5_gnt");
    k = 0;
    while (!rsp_valid[1] && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    check("t5_drain_started", rsp_valid[1], 1'b1);
    repeat (3) @(negedge CLK);
    req = 2'b00;
    wait_gnt(2'b00, 1000, "t5_done");
    check("t5_q1_empty", exp_q1.size(), 0);
    repeat (10) @(negedge CLK);
    check("t5_no_regrant", gnt, 0);
    gap_mem = 1'b0;

    // req 1 alone with rr_ptr back at 0: grant one cycle later.
    load_batch(1, 1'b0);
    @(posedge CLK);
    #2 req = 2'b10;
    @(negedge CLK);
    check("t6_gnt_not_yet", gnt, 2'b00);
    @(negedge CLK);
    check("t6_gnt_latency1", gnt, 2'b10);
    req = 2'b00;
    wait_gnt(2'b00, 1000, "t6_done");
    check("t6_q1_empty", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
